// File: rtl/acc_dispatcher_mc.sv
// acc_dispatcher_mc: in-order accelerator issue queue released on commit,
// opcode-routed to NumAcc channels, responses round-robin to one writeback.
//
// Ports:
//   clk_i, rst_i (async, active high), flush_i
//   acc_valid_i/acc_ready_o, acc_insn_i, acc_rs1_i, acc_rs2_i, acc_trans_id_i
//   acc_commit_i, acc_commit_trans_id_i
//   acc_valid_o, acc_trans_id_o, acc_result_o, acc_exception_o, acc_busy_o
//   req_valid_o/req_ready_i, req_insn_o, req_rs1_o, req_rs2_o, req_trans_id_o
//   resp_valid_i/resp_ready_o, resp_result_i, resp_trans_id_i, resp_error_i

package acc_dispatcher_mc_pkg;

    localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

endpackage

module acc_dispatcher_mc
    import acc_dispatcher_mc_pkg::*;
#(
    parameter int NumAcc         = 2,
    parameter int Depth          = 4,
    parameter int MaxOutstanding = 4,
    parameter int XLEN           = 64,
    parameter int TransIdBits    = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          acc_valid_i,
    output logic                          acc_ready_o,
    input  logic [31:0]                   acc_insn_i,
    input  logic [XLEN-1:0]               acc_rs1_i,
    input  logic [XLEN-1:0]               acc_rs2_i,
    input  logic [TransIdBits-1:0]        acc_trans_id_i,
    input  logic                          acc_commit_i,
    input  logic [TransIdBits-1:0]        acc_commit_trans_id_i,
    output logic                          acc_valid_o,
    output logic [TransIdBits-1:0]        acc_trans_id_o,
    output logic [XLEN-1:0]               acc_result_o,
    output exception_t                    acc_exception_o,
    output logic                          acc_busy_o,
    output logic [NumAcc-1:0]             req_valid_o,
    input  logic [NumAcc-1:0]             req_ready_i,
    output logic [NumAcc*32-1:0]          req_insn_o,
    output logic [NumAcc*XLEN-1:0]        req_rs1_o,
    output logic [NumAcc*XLEN-1:0]        req_rs2_o,
    output logic [NumAcc*TransIdBits-1:0] req_trans_id_o,
    input  logic [NumAcc-1:0]             resp_valid_i,
    output logic [NumAcc-1:0]             resp_ready_o,
    input  logic [NumAcc*XLEN-1:0]        resp_result_i,
    input  logic [NumAcc*TransIdBits-1:0] resp_trans_id_i,
    input  logic [NumAcc-1:0]             resp_error_i
);

    localparam int PW = $clog2(Depth);
    localparam int CW = (NumAcc > 1) ? $clog2(NumAcc) : 1;
    localparam int OW = $clog2(MaxOutstanding + 1);

    // Issue queue
    logic [PW-1:0]          r_head;
    logic [PW-1:0]          r_tail;
    logic [Depth-1:0]       r_vld;
    logic [Depth-1:0]       r_cmt;
    logic [31:0]            r_q_insn [Depth];
    logic [XLEN-1:0]        r_q_rs1  [Depth];
    logic [XLEN-1:0]        r_q_rs2  [Depth];
    logic [TransIdBits-1:0] r_q_id   [Depth];

    // Per-channel output registers and outstanding counters
    logic [NumAcc-1:0]      r_req_vld;
    logic [31:0]            r_req_insn [NumAcc];
    logic [XLEN-1:0]        r_req_rs1  [NumAcc];
    logic [XLEN-1:0]        r_req_rs2  [NumAcc];
    logic [TransIdBits-1:0] r_req_id   [NumAcc];
    logic [OW-1:0]          r_out      [NumAcc];

    // Local illegal-instruction slot
    logic                   r_err_vld;
    logic [31:0]            r_err_insn;
    logic [TransIdBits-1:0] r_err_id;

    // Arbitration and writeback
    logic [CW-1:0]          r_rr;
    logic                   r_wb_vld;
    logic [TransIdBits-1:0] r_wb_id;
    logic [XLEN-1:0]        r_wb_result;
    exception_t             r_wb_exc;

    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_head_rdy;
    logic [31:0]            w_head_insn;
    logic [1:0]             w_ch;
    logic                   w_local;
    logic [NumAcc-1:0]      w_ld;
    logic                   w_err_ld;
    logic [PW:0]            w_ncmt;
    logic [NumAcc-1:0]      w_resp_rdy;
    logic                   w_grant_any;
    logic [CW-1:0]          w_grant_ch;
    logic [XLEN-1:0]        w_g_result;
    logic [TransIdBits-1:0] w_g_id;
    logic                   w_g_err;
    logic                   w_any_out;

    // Entries are contiguous from head, so the tail slot is busy only when full.
    assign w_full      = r_vld[r_tail];
    assign w_push      = acc_valid_i && !w_full && !flush_i;
    assign w_head_rdy  = r_vld[r_head] && r_cmt[r_head];
    assign w_head_insn = r_q_insn[r_head];
    assign w_ch        = w_head_insn[6:5];
    assign w_local     = int'(w_ch) >= NumAcc;

    // Response arbitration: local error slot first, else round-robin.
    always_comb begin : arb
        int idx;
        idx         = 0;
        w_resp_rdy  = '0;
        w_grant_any = 1'b0;
        w_grant_ch  = '0;
        w_g_result  = '0;
        w_g_id      = '0;
        w_g_err     = 1'b0;
        if (!r_err_vld) begin
            for (int k = 0; k < NumAcc; k++) begin
                idx = (int'(r_rr) + k) % NumAcc;
                if (!w_grant_any && resp_valid_i[idx]) begin
                    w_grant_any     = 1'b1;
                    w_grant_ch      = CW'(idx);
                    w_resp_rdy[idx] = 1'b1;
                    w_g_result      = resp_result_i[idx*XLEN +: XLEN];
                    w_g_id          = resp_trans_id_i[idx*TransIdBits +: TransIdBits];
                    w_g_err         = resp_error_i[idx];
                end
            end
        end
    end

    // Head release; a response accepted this cycle frees a credit at once.
    always_comb begin
        w_pop    = 1'b0;
        w_ld     = '0;
        w_err_ld = 1'b0;
        if (w_head_rdy) begin
            if (w_local) begin
                if (!r_err_vld) begin
                    w_pop    = 1'b1;
                    w_err_ld = 1'b1;
                end
            end else begin
                for (int c = 0; c < NumAcc; c++) begin
                    if (int'(w_ch) == c
                        && (!r_req_vld[c] || req_ready_i[c])
                        && (int'(r_out[c]) < MaxOutstanding || w_resp_rdy[c])) begin
                        w_pop   = 1'b1;
                        w_ld[c] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_ncmt = '0;
        for (int i = 0; i < Depth; i++) begin
            w_ncmt = w_ncmt + (PW+1)'(r_vld[i] & r_cmt[i]);
        end
    end

    always_comb begin
        w_any_out = 1'b0;
        for (int c = 0; c < NumAcc; c++) begin
            w_any_out = w_any_out | (r_out[c] != '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_vld  <= '0;
            r_cmt  <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_q_insn[i] <= '0;
                r_q_rs1[i]  <= '0;
                r_q_rs2[i]  <= '0;
                r_q_id[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (acc_commit_i && r_vld[i]
                    && r_q_id[i] == acc_commit_trans_id_i) begin
                    r_cmt[i] <= 1'b1;
                end
            end
            if (w_push) begin
                r_q_insn[r_tail] <= acc_insn_i;
                r_q_rs1[r_tail]  <= acc_rs1_i;
                r_q_rs2[r_tail]  <= acc_rs2_i;
                r_q_id[r_tail]   <= acc_trans_id_i;
                r_vld[r_tail]    <= 1'b1;
                r_cmt[r_tail]    <= acc_commit_i
                    && (acc_trans_id_i == acc_commit_trans_id_i);
                r_tail           <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_cmt[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            // Committed entries are a prefix, so the new tail is head + count.
            if (flush_i) begin
                for (int i = 0; i < Depth; i++) begin
                    if (!r_cmt[i]) begin
                        r_vld[i] <= 1'b0;
                        r_cmt[i] <= 1'b0;
                    end
                end
                r_tail <= r_head + w_ncmt[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_vld <= '0;
            for (int c = 0; c < NumAcc; c++) begin
                r_req_insn[c] <= '0;
                r_req_rs1[c]  <= '0;
                r_req_rs2[c]  <= '0;
                r_req_id[c]   <= '0;
                r_out[c]      <= '0;
            end
        end else begin
            for (int c = 0; c < NumAcc; c++) begin
                if (w_ld[c]) begin
                    r_req_vld[c]  <= 1'b1;
                    r_req_insn[c] <= w_head_insn;
                    r_req_rs1[c]  <= r_q_rs1[r_head];
                    r_req_rs2[c]  <= r_q_rs2[r_head];
                    r_req_id[c]   <= r_q_id[r_head];
                end else if (req_ready_i[c]) begin
                    r_req_vld[c] <= 1'b0;
                end
                r_out[c] <= r_out[c] + OW'(w_ld[c]) - OW'(w_resp_rdy[c]);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_vld   <= 1'b0;
            r_err_insn  <= '0;
            r_err_id    <= '0;
            r_rr        <= '0;
            r_wb_vld    <= 1'b0;
            r_wb_id     <= '0;
            r_wb_result <= '0;
            r_wb_exc    <= '0;
        end else begin
            r_wb_vld <= 1'b0;
            if (w_err_ld) begin
                r_err_vld  <= 1'b1;
                r_err_insn <= w_head_insn;
                r_err_id   <= r_q_id[r_head];
            end else if (r_err_vld) begin
                r_err_vld <= 1'b0;
            end
            if (r_err_vld) begin
                r_wb_vld    <= 1'b1;
                r_wb_id     <= r_err_id;
                r_wb_result <= '0;
                r_wb_exc    <= '{cause: ILLEGAL_INSTR,
                                 tval:  64'(r_err_insn),
                                 valid: 1'b1};
            end else if (w_grant_any) begin
                r_wb_vld       <= 1'b1;
                r_wb_id        <= w_g_id;
                r_wb_result    <= w_g_result;
                r_wb_exc.cause <= w_g_err ? ILLEGAL_INSTR : '0;
                r_wb_exc.tval  <= '0;
                r_wb_exc.valid <= w_g_err;
                if (w_grant_ch == CW'(NumAcc - 1)) begin
                    r_rr <= '0;
                end else begin
                    r_rr <= w_grant_ch + 1'b1;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NumAcc; g++) begin : g_req
            assign req_insn_o[g*32 +: 32]                   = r_req_insn[g];
            assign req_rs1_o[g*XLEN +: XLEN]                = r_req_rs1[g];
            assign req_rs2_o[g*XLEN +: XLEN]                = r_req_rs2[g];
            assign req_trans_id_o[g*TransIdBits +: TransIdBits] = r_req_id[g];
        end
    endgenerate

    assign acc_ready_o     = !w_full;
    assign req_valid_o     = r_req_vld;
    assign resp_ready_o    = w_resp_rdy;
    assign acc_valid_o     = r_wb_vld;
    assign acc_trans_id_o  = r_wb_id;
    assign acc_result_o    = r_wb_result;
    assign acc_exception_o = r_wb_exc;
    assign acc_busy_o      = (|r_vld) || w_any_out;

endmodule

// File: tb/tb_acc_dispatcher_mc.sv
// tb_acc_dispatcher_mc: directed table plus hand sequences for
// acc_dispatcher_mc (NumAcc=2, Depth=4, MaxOutstanding=2).

module tb_acc_dispatcher_mc;
    import acc_dispatcher_mc_pkg::*;

    localparam int NA = 2;
    localparam int DP = 4;
    localparam int MO = 2;
    localparam int XL = 64;
    localparam int TB = 3;

    logic               clk;
    logic               rst;
    logic               flush_i;
    logic               acc_valid_i;
    logic               acc_ready_o;
    logic [31:0]        acc_insn_i;
    logic [XL-1:0]      acc_rs1_i;
    logic [XL-1:0]      acc_rs2_i;
    logic [TB-1:0]      acc_trans_id_i;
    logic               acc_commit_i;
    logic [TB-1:0]      acc_commit_trans_id_i;
    logic               acc_valid_o;
    logic [TB-1:0]      acc_trans_id_o;
    logic [XL-1:0]      acc_result_o;
    exception_t         acc_exception_o;
    logic               acc_busy_o;
    logic [NA-1:0]      req_valid_o;
    logic [NA-1:0]      req_ready_i;
    logic [NA*32-1:0]   req_insn_o;
    logic [NA*XL-1:0]   req_rs1_o;
    logic [NA*XL-1:0]   req_rs2_o;
    logic [NA*TB-1:0]   req_trans_id_o;
    logic [NA-1:0]      resp_valid_i;
    logic [NA-1:0]      resp_ready_o;
    logic [NA*XL-1:0]   resp_result_i;
    logic [NA*TB-1:0]   resp_trans_id_i;
    logic [NA-1:0]      resp_error_i;

    acc_dispatcher_mc #(
        .NumAcc(NA), .Depth(DP), .MaxOutstanding(MO),
        .XLEN(XL), .TransIdBits(TB)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .flush_i              (flush_i),
        .acc_valid_i          (acc_valid_i),
        .acc_ready_o          (acc_ready_o),
        .acc_insn_i           (acc_insn_i),
        .acc_rs1_i            (acc_rs1_i),
        .acc_rs2_i            (acc_rs2_i),
        .acc_trans_id_i       (acc_trans_id_i),
        .acc_commit_i         (acc_commit_i),
        .acc_commit_trans_id_i(acc_commit_trans_id_i),
        .acc_valid_o          (acc_valid_o),
        .acc_trans_id_o       (acc_trans_id_o),
        .acc_result_o         (acc_result_o),
        .acc_exception_o      (acc_exception_o),
        .acc_busy_o           (acc_busy_o),
        .req_valid_o          (req_valid_o),
        .req_ready_i          (req_ready_i),
        .req_insn_o           (req_insn_o),
        .req_rs1_o            (req_rs1_o),
        .req_rs2_o            (req_rs2_o),
        .req_trans_id_o       (req_trans_id_o),
        .resp_valid_i         (resp_valid_i),
        .resp_ready_o         (resp_ready_o),
        .resp_result_i        (resp_result_i),
        .resp_trans_id_i      (resp_trans_id_i),
        .resp_error_i         (resp_error_i)
    );

    typedef struct {
        logic [31:0]   insn;
        logic [XL-1:0] rs1;
        logic [XL-1:0] rs2;
        logic [TB-1:0] id;
        logic [NA-1:0] req;
        int            ch;
        logic          loc;
        logic          err;
        logic [XL-1:0] res;
    } vec_t;

    vec_t vt [6];
    int   checks = 0;
    int   errors = 0;
    int   hs [NA];
    int   b0;
    int   b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int c = 0; c < NA; c++) hs[c] = 0;
    end

    always @(posedge clk) begin
        for (int c = 0; c < NA; c++) begin
            if (req_valid_o[c] && req_ready_i[c]) hs[c] = hs[c] + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NA; c++) begin
                if (int'(dut.r_out[c]) > MO) begin
                    errors++;
                    $display("FAIL outstanding_over ch%0d: got %0d, limit %0d",
                             c, dut.r_out[c], MO);
                end
                if (resp_valid_i[c] && resp_ready_o[c] && dut.r_out[c] == 0) begin
                    errors++;
                    $display("FAIL outstanding_under ch%0d: got 0, need >0", c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i               = 1'b0;
        acc_valid_i           = 1'b0;
        acc_insn_i            = '0;
        acc_rs1_i             = '0;
        acc_rs2_i             = '0;
        acc_trans_id_i        = '0;
        acc_commit_i          = 1'b0;
        acc_commit_trans_id_i = '0;
        req_ready_i           = '0;
        resp_valid_i          = '0;
        resp_result_i         = '0;
        resp_trans_id_i       = '0;
        resp_error_i          = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push(input logic [31:0] insn, input logic [TB-1:0] id,
                        input logic cm);
        acc_valid_i           = 1'b1;
        acc_insn_i            = insn;
        acc_rs1_i             = {32'h0, insn};
        acc_rs2_i             = {insn, 32'h0};
        acc_trans_id_i        = id;
        acc_commit_i          = cm;
        acc_commit_trans_id_i = id;
        tick();
        acc_valid_i  = 1'b0;
        acc_commit_i = 1'b0;
    endtask

    task automatic respond(input int ch, input logic [TB-1:0] id);
        resp_valid_i                  = '0;
        resp_valid_i[ch]              = 1'b1;
        resp_trans_id_i[ch*TB +: TB]  = id;
        resp_error_i                  = '0;
        tick();
        resp_valid_i = '0;
    endtask

    initial begin
        vt[0] = '{32'h0000002B, 64'h1111, 64'h2222, 3'd3, 2'b10, 1, 1'b0, 1'b0, 64'hA1};
        vt[1] = '{32'h0000000B, 64'h3333, 64'h4444, 3'd1, 2'b01, 0, 1'b0, 1'b1, 64'hB2};
        vt[2] = '{32'h0000005B, 64'h5555, 64'h6666, 3'd5, 2'b00, 0, 1'b1, 1'b0, 64'h0};
        vt[3] = '{32'h0000007B, 64'h7777, 64'h8888, 3'd6, 2'b00, 0, 1'b1, 1'b0, 64'h0};
        vt[4] = '{32'h1234500B, 64'h9999, 64'hAAAA, 3'd7, 2'b01, 0, 1'b0, 1'b0, 64'hC3};
        vt[5] = '{32'hABCDE02B, 64'hBBBB, 64'hCCCC, 3'd0, 2'b10, 1, 1'b0, 1'b1, 64'hD4};

        rst = 1'b1;
        idle();
        #2;
        chk("rst_ready", acc_ready_o, 1);
        chk("rst_busy", acc_busy_o, 0);
        chk("rst_req_valid", req_valid_o, 0);
        chk("rst_acc_valid", acc_valid_o, 0);
        chk("rst_resp_ready", resp_ready_o, 0);
        chk("rst_exc_valid", acc_exception_o.valid, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            acc_valid_i           = 1'b1;
            acc_insn_i            = vt[i].insn;
            acc_rs1_i             = vt[i].rs1;
            acc_rs2_i             = vt[i].rs2;
            acc_trans_id_i        = vt[i].id;
            acc_commit_i          = 1'b1;
            acc_commit_trans_id_i = vt[i].id;
            tick();
            acc_valid_i  = 1'b0;
            acc_commit_i = 1'b0;
            tick();
            chk($sformatf("v%0d_req_valid", i), req_valid_o, vt[i].req);
            if (vt[i].loc) begin
                tick();
                chk($sformatf("v%0d_wb_valid", i), acc_valid_o, 1);
                chk($sformatf("v%0d_wb_id", i), acc_trans_id_o, vt[i].id);
                chk($sformatf("v%0d_exc_valid", i), acc_exception_o.valid, 1);
                chk($sformatf("v%0d_exc_cause", i), acc_exception_o.cause, 2);
                chk($sformatf("v%0d_exc_tval", i), acc_exception_o.tval,
                    {32'h0, vt[i].insn});
                chk($sformatf("v%0d_no_req", i), req_valid_o, 0);
            end else begin
                chk($sformatf("v%0d_req_insn", i),
                    req_insn_o[vt[i].ch*32 +: 32], vt[i].insn);
                chk($sformatf("v%0d_req_rs1", i),
                    req_rs1_o[vt[i].ch*XL +: XL], vt[i].rs1);
                chk($sformatf("v%0d_req_rs2", i),
                    req_rs2_o[vt[i].ch*XL +: XL], vt[i].rs2);
                chk($sformatf("v%0d_req_id", i),
                    req_trans_id_o[vt[i].ch*TB +: TB], vt[i].id);
                req_ready_i = vt[i].req;
                tick();
                req_ready_i = '0;
                chk($sformatf("v%0d_req_drop", i), req_valid_o, 0);
                resp_valid_i                       = vt[i].req;
                resp_result_i                      = '0;
                resp_result_i[vt[i].ch*XL +: XL]   = vt[i].res;
                resp_trans_id_i                    = '0;
                resp_trans_id_i[vt[i].ch*TB +: TB] = vt[i].id;
                resp_error_i                       = '0;
                resp_error_i[vt[i].ch]             = vt[i].err;
                #1;
                chk($sformatf("v%0d_resp_ready", i), resp_ready_o, vt[i].req);
                tick();
                resp_valid_i = '0;
                chk($sformatf("v%0d_wb_valid", i), acc_valid_o, 1);
                chk($sformatf("v%0d_wb_id", i), acc_trans_id_o, vt[i].id);
                chk($sformatf("v%0d_wb_result", i), acc_result_o, vt[i].res);
                chk($sformatf("v%0d_exc_valid", i), acc_exception_o.valid,
                    vt[i].err);
                if (vt[i].err) begin
                    chk($sformatf("v%0d_exc_cause", i), acc_exception_o.cause, 2);
                    chk($sformatf("v%0d_exc_tval", i), acc_exception_o.tval, 0);
                end
                chk($sformatf("v%0d_busy", i), acc_busy_o, 0);
            end
            tick();
            chk($sformatf("v%0d_wb_pulse", i), acc_valid_o, 0);
            idle();
        end

        // Held until commit, then held until ready
        push(32'h0000002B, 3'd3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("nocommit_req", req_valid_o, 0);
            tick();
        end
        acc_commit_i          = 1'b1;
        acc_commit_trans_id_i = 3'd3;
        tick();
        acc_commit_i = 1'b0;
        tick();
        chk("commit_req", req_valid_o, 2'b10);
        chk("commit_rs1", req_rs1_o[XL +: XL], 64'h000000000000002B);
        chk("commit_rs2", req_rs2_o[XL +: XL], 64'h0000002B00000000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_req", req_valid_o, 2'b10);
            chk("hold_insn", req_insn_o[32 +: 32], 32'h0000002B);
        end
        req_ready_i = 2'b10;
        tick();
        req_ready_i = '0;
        chk("hold_drop", req_valid_o, 0);
        respond(1, 3'd3);
        chk("hold_wb_id", acc_trans_id_o, 3);
        tick();

        // Outstanding limit on channel 0
        do_reset();
        b0 = hs[0];
        req_ready_i = 2'b01;
        push(32'h0000000B, 3'd1, 1'b1);
        push(32'h0000000B, 3'd2, 1'b1);
        push(32'h0000000B, 3'd3, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        chk("limit_dispatched", hs[0] - b0, 2);
        chk("limit_req_idle", req_valid_o[0], 0);
        chk("limit_busy", acc_busy_o, 1);
        resp_valid_i       = 2'b01;
        resp_trans_id_i    = '0;
        resp_trans_id_i[2:0] = 3'd1;
        #1;
        chk("limit_resp_ready", resp_ready_o, 2'b01);
        tick();
        resp_valid_i = '0;
        chk("limit_third_req", req_valid_o[0], 1);
        chk("limit_third_id", req_trans_id_o[2:0], 3);
        chk("limit_out_2", dut.r_out[0], 2);
        chk("limit_wb_id", acc_trans_id_o, 1);
        tick();
        chk("limit_dispatched3", hs[0] - b0, 3);
        req_ready_i = '0;
        respond(0, 3'd2);
        respond(0, 3'd3);
        chk("limit_busy_end", acc_busy_o, 0);
        tick();

        // Round-robin with both channels responding continuously
        do_reset();
        req_ready_i = 2'b11;
        push(32'h0000000B, 3'd1, 1'b1);
        push(32'h0000000B, 3'd2, 1'b1);
        push(32'h0000002B, 3'd3, 1'b1);
        push(32'h0000002B, 3'd4, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        req_ready_i     = '0;
        resp_valid_i    = 2'b11;
        resp_trans_id_i = {3'd3, 3'd1};
        resp_result_i   = {64'h5555, 64'hAAAA};
        resp_error_i    = 2'b10;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr%0d_grant", k), resp_ready_o,
                (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk($sformatf("rr%0d_wb_valid", k), acc_valid_o, 1);
            chk($sformatf("rr%0d_wb_id", k), acc_trans_id_o,
                (k % 2 == 0) ? 3 'd1 : 3'd3);
            chk($sformatf("rr%0d_exc_valid", k), acc_exception_o.valid,
                (k % 2 == 0) ? 1'b0 : 1'b1);
            chk($sformatf("rr%0d_exc_tval", k), acc_exception_o.tval, 0);
            if (k % 2 == 1) begin
                chk($sformatf("rr%0d_exc_cause", k), acc_exception_o.cause, 2);
            end
        end
        resp_valid_i = '0;
        tick();
        chk("rr_pulse_end", acc_valid_o, 0);
        chk("rr_busy", acc_busy_o, 0);

        // Fill, partial commit, flush
        do_reset();
        push(32'h0000000B, 3'd1, 1'b0);
        push(32'h0000000B, 3'd2, 1'b0);
        push(32'h0000002B, 3'd3, 1'b0);
        push(32'h0000002B, 3'd4, 1'b0);
        chk("full_ready", acc_ready_o, 0);
        b0 = hs[0];
        b1 = hs[1];
        req_ready_i           = 2'b11;
        acc_commit_i          = 1'b1;
        acc_commit_trans_id_i = 3'd1;
        tick();
        acc_commit_trans_id_i = 3'd2;
        tick();
        acc_commit_i = 1'b0;
        flush_i      = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_ready", acc_ready_o, 1);
        for (int k = 0; k < 4; k++) tick();
        chk("flush_ch0_sent", hs[0] - b0, 2);
        chk("flush_ch1_sent", hs[1] - b1, 0);
        chk("flush_busy", acc_busy_o, 1);
        req_ready_i = '0;
        respond(0, 3'd1);
        chk("flush_busy_mid", acc_busy_o, 1);
        respond(0, 3'd2);
        chk("flush_busy_end", acc_busy_o, 0);
        tick();

        // Asynchronous reset mid-dispatch
        push(32'h0000002B, 3'd2, 1'b1);
        tick();
        chk("arst_pre_req", req_valid_o, 2'b10);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_req", req_valid_o, 0);
        chk("arst_ready", acc_ready_o, 1);
        chk("arst_busy", acc_busy_o, 0);
        chk("arst_acc_valid", acc_valid_o, 0);
        chk("arst_resp_ready", resp_ready_o, 0);
        chk("arst_exc", acc_exception_o.valid, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
